keypad_scan: RTL
================

// Module: keypad_scan
// PURPOSE
//   Input-side counterpart of the multiplexed 7-seg display driver: scans a 4x4
//   matrix keypad (Pmod KYPD), one column at a time. Debounces presses and releases.
//   Emits a one-cycle strobe with the hex code of each newly accepted key.
//   Key codes feed the control FSM and the display digit registers.
// PARAMETERS
//   SCAN_COUNT     100000  clk cycles each column is driven (1 ms at 100 MHz); must be >= 4
//   DEBOUNCE_SCANS 4       consecutive scan frames required to accept a press or a release; >= 1
// PORTS
//   clk        in   1  system clock (100 MHz)
//   rst_n      in   1  asynchronous, active-low reset
//   row        in   4  keypad rows, active-low, externally pulled up, asynchronous to clk
//   col        out  4  keypad columns, active-low, exactly one bit low at all times
//   key_code   out  4  hex value of accepted key; holds value until next accepted key
//   key_valid  out  1  one-cycle pulse when a new key is accepted
//   key_held   out  1  high while accepted key is considered pressed
// BEHAVIOUR
// - Reset values (async on rst_n low):
//   - col=4'b1110, key_code=0, key_valid=0, key_held=0.
//   - Dwell counter=0, column index=0, state=IDLE, debounce count=0.
//   - Row synchronisers=4'b1111.
// - row passes through a 2-FF synchroniser before any use.
// - Column scan:
//   - Dwell counter counts 0..SCAN_COUNT-1, width $clog2(SCAN_COUNT).
//   - At SCAN_COUNT-1 it wraps to 0 and column index increments, wrapping 3->0.
//   - col = ~(4'b0001 << index): 1110, 1101, 1011, 0111.
// - Row sampling:
//   - Synchronised row is sampled on the last dwell cycle (counter==SCAN_COUNT-1) of each column.
//   - A low bit r marks key (r, column index) pressed.
// - Scan frame = 4 columns = 4*SCAN_COUNT cycles; it ends at the column-3 sample.
// - Frame result: NONE (0 keys), SINGLE(code) (exactly 1 key), MULTI (>=2 keys).
// - Code map, row r / col c:
//   - r0: 1 2 3 A
//   - r1: 4 5 6 B
//   - r2: 7 8 9 C
//   - r3: 0 F E D
// - FSM is evaluated only at frame end; cnt is the debounce count.
//   - IDLE:
//     - SINGLE(k) -> DEBOUNCE, cand=k, cnt=1.
//     - If DEBOUNCE_SCANS==1, accept immediately as below.
//     - Otherwise stay in IDLE.
//   - DEBOUNCE:
//     - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS -> PRESSED (accept).
//     - SINGLE(other): restart with cand=other, cnt=1.
//     - NONE or MULTI -> IDLE.
//   - Accept:
//     - key_code<=cand and key_valid=1 for exactly the cycle after the frame-end sample.
//     - key_held<=1 on the same edge.
//   - PRESSED:
//     - SINGLE(cand): stay.
//     - Any other result -> RELEASE, cnt=1.
//   - RELEASE:
//     - NONE: cnt+1. When cnt reaches DEBOUNCE_SCANS -> IDLE, key_held<=0.
//     - SINGLE(cand) -> PRESSED, no new pulse.
//     - SINGLE(other) or MULTI: stay, cnt=0.
// - Only one key_valid pulse per accepted press; holding a key never auto-repeats.
// - Latency: key stable from a frame start -> key_valid DEBOUNCE_SCANS frames later (+1 clk).
// - Mid-operation reset: all state abandoned immediately; scan restarts at column 0.
// TESTING (bench: SCAN_COUNT=4, DEBOUNCE_SCANS=3; keypad model drives row combinationally from col)
//   1. Reset, no keys -> outputs 0, col=1110.
//      col steps 1101/1011/0111 every 4 clks; back to 1110 at clk 16.
//   2. Hold key '5' (row1 low when col=1101) 13 frames -> exactly one key_valid, key_code=4'h5.
//      key_held=1 thereafter.
//   3. Key '9' present 2 frames, then absent -> no key_valid; key_code keeps prior value.
//   4. From held '5': release 1 frame then '5' again -> key_held stays 1, no pulse.
//      Then release 3 frames -> key_held=0.
//   5. Keys '1'+'2' together from IDLE -> no pulse.
//      Then 'D' alone (row3, col=0111) 3 frames -> key_code=4'hD, single pulse.
//   6. Assert rst_n=0 mid-DEBOUNCE and mid-PRESSED -> all outputs reset the same cycle, col=1110.
//      No pulse after release of reset until a fresh 3-frame press.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: column-multiplexed 4x4 matrix keypad scanner.
// Drives one column low at a time and samples the synchronised rows at the end
// of each column dwell. It classifies every 4-column frame as none, single or
// multi, debounces presses and releases over whole frames, and emits one
// key_valid strobe per accepted key.

// Two-flop synchroniser for one keypad row. Rows idle high because of the
// external pull-ups, so both flops reset to 1.
module keypad_row_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Two-stage synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module keypad_scan #(
  parameter int SCAN_COUNT     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int CW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [CW-1:0] dwell;
  logic [1:0]    idx;
  logic [3:0]    row_s;
  logic          sample;
  logic          frame_end;

  // Frame accumulator: number of keys seen so far (saturating at 2) and the
  // code of the first key found.
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;

  // Per-column decode and the running frame totals
  logic [3:0]    hits;
  logic [2:0]    col_n;
  logic [3:0]    col_code;
  logic [2:0]    sum3;
  logic [1:0]    tot;
  logic [3:0]    tot_code;

  // Debounce FSM
  state_t        state;
  logic [3:0]    cand;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_inc;
  logic          res_none;
  logic          res_single;
  logic          res_cand;
  logic          cnt_done;

  // Hex code of the key at row r, column c
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'h0;
      4'b11_01: k = 4'hF;
      4'b11_10: k = 4'hE;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // One synchroniser instance per row bit
  keypad_row_sync u_sync [3:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_s)
  );

  assign sample    = (dwell == CW'(SCAN_COUNT - 1));
  assign frame_end = sample && (idx == 2'd3);
  assign col       = ~(4'b0001 << idx);

  // Dwell counter and column index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      idx   <= 2'd0;
    end else if (sample) begin
      dwell <= '0;
      idx   <= idx + 2'd1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // Decode the active column and merge it with the partial frame result
  always_comb begin
    hits     = ~row_s;
    col_n    = 3'd0;
    col_code = 4'h0;
    // descending so the lowest pressed row supplies the code
    for (int r = 3; r >= 0; r--) begin
      if (hits[r]) begin
        col_n    = col_n + 3'd1;
        col_code = key_map(2'(r), idx);
      end
    end
    sum3     = {1'b0, acc_cnt} + col_n;
    tot      = (sum3 >= 3'd2) ? 2'd2 : sum3[1:0];
    tot_code = (acc_cnt != 2'd0) ? acc_code : col_code;
  end

  // Accumulate column samples; cleared as the frame-end sample is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      if (idx == 2'd3) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'h0;
      end else begin
        acc_cnt  <= tot;
        acc_code <= tot_code;
      end
    end
  end

  assign res_none   = (tot == 2'd0);
  assign res_single = (tot == 2'd1);
  assign res_cand   = res_single && (tot_code == cand);
  assign cnt_inc    = cnt + 1'b1;
  assign cnt_done   = (cnt_inc == DW'(DEBOUNCE_SCANS));

  // Frame-level debounce FSM with registered key outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 4'h0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (res_single) begin
              cand <= tot_code;
              if (DEBOUNCE_SCANS == 1) begin
                key_code  <= tot_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                state     <= PRESSED;
              end else begin
                cnt   <= DW'(1);
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (res_cand) begin
              if (cnt_done) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                state     <= PRESSED;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (res_single) begin
              cand <= tot_code;
              cnt  <= DW'(1);
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
          PRESSED: begin
            if (!res_cand) begin
              // a single debounce frame makes the first empty frame final
              if (DEBOUNCE_SCANS == 1 && res_none) begin
                key_held <= 1'b0;
                cnt      <= '0;
                state    <= IDLE;
              end else begin
                cnt   <= DW'(1);
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (res_none) begin
              if (cnt_done) begin
                key_held <= 1'b0;
                cnt      <= '0;
                state    <= IDLE;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (res_cand) begin
              cnt   <= '0;
              state <= PRESSED;
            end else begin
              cnt <= '0;
            end
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule
